// File: rtl/bitcnt_pkg.sv
// rtl/bitcnt_pkg.sv - shared constants, CSR map and FSM state type for the popcount memory reader
package bitcnt_pkg;

    // Memory geometry and result width
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 64;
    localparam int CNT_W   = 17;
    localparam int LEN_W   = 11;
    localparam int LEN_MAX = 1024;
    localparam int POP_W   = 7;

    // CSR word offsets
    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_BASE   = 2'd1;
    localparam logic [1:0] CSR_LEN    = 2'd2;
    localparam logic [1:0] CSR_RESULT = 2'd3;

    // CTRL write bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;

    // CTRL read bits
    localparam int CTRL_BUSY_BIT = 0;
    localparam int CTRL_DONE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/bitcnt_popcount64.sv
// rtl/bitcnt_popcount64.sv - combinational 64-bit population count adder tree
//
// Ports:
//   i_data  in  64  word to count
//   o_count out 7   number of set bits (0..64)
module bitcnt_popcount64
    import bitcnt_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [POP_W-1:0]  o_count
);

    logic [1:0] w_s1 [32];
    logic [2:0] w_s2 [16];
    logic [3:0] w_s3 [8];
    logic [4:0] w_s4 [4];
    logic [5:0] w_s5 [2];

    // Each level adds adjacent pairs, growing the width by one bit.
    for (genvar i = 0; i < 32; i++) begin : g_l1
        assign w_s1[i] = {1'b0, i_data[2*i]} + {1'b0, i_data[2*i+1]};
    end
    for (genvar i = 0; i < 16; i++) begin : g_l2
        assign w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
    end
    for (genvar i = 0; i < 8; i++) begin : g_l3
        assign w_s3[i] = {1'b0, w_s2[2*i]} + {1'b0, w_s2[2*i+1]};
    end
    for (genvar i = 0; i < 4; i++) begin : g_l4
        assign w_s4[i] = {1'b0, w_s3[2*i]} + {1'b0, w_s3[2*i+1]};
    end
    for (genvar i = 0; i < 2; i++) begin : g_l5
        assign w_s5[i] = {1'b0, w_s4[2*i]} + {1'b0, w_s4[2*i+1]};
    end

    assign o_count = {1'b0, w_s5[0]} + {1'b0, w_s5[1]};

endmodule

// File: rtl/bitcnt_mem_reader.sv
// rtl/bitcnt_mem_reader.sv - streams a window of on-chip memory and accumulates its total ones count
//
// Optional feature macro: BITCNT_MEM_READER_IRQ_EN (adds irq output and CTRL irq_enable bit).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   csr_*               register slave: 0 CTRL, 1 BASE, 2 LEN, 3 RESULT; readdata one cycle after read
//   mem_address         memory word address (wraps modulo depth)
//   mem_chipselect      high on each word-issue cycle only
//   mem_write/mem_clken tied 0 / 1
//   mem_readdata        memory q, valid the cycle after issue
//   irq                 (macro only) registered done & irq_enable
module bitcnt_mem_reader
    import bitcnt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
`ifdef BITCNT_MEM_READER_IRQ_EN
    ,
    output logic              irq
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [CNT_W-1:0]   r_result;
    logic               r_done;
    logic               r_rd_valid;
    logic [31:0]        r_readdata;

    logic               w_wr;
    logic               w_rd;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_busy;
    logic               w_issue;
    logic [LEN_W-1:0]   w_len_in;
    logic [POP_W-1:0]   w_pop;
    logic [31:0]        w_ctrl_rd;
    logic [31:0]        w_rd_mux;
    logic               w_unused_bits;

    assign w_wr      = csr_chipselect & csr_write;
    assign w_rd      = csr_chipselect & csr_read;
    assign w_ctrl_wr = w_wr && (csr_address == CSR_CTRL);
    assign w_start   = w_ctrl_wr && csr_writedata[CTRL_START_BIT] && (r_state == IDLE);
    // FIN counts as busy: done only becomes visible once the FSM is back in IDLE.
    assign w_busy    = (r_state != IDLE);

    assign w_len_in = (csr_writedata[LEN_W-1:0] > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX)
                                                                   : csr_writedata[LEN_W-1:0];

    assign w_unused_bits = ^csr_writedata[31:LEN_W];

    bitcnt_popcount64 u_pop (
        .i_data  (mem_readdata),
        .o_count (w_pop)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = (r_len != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_idx == (r_len - LEN_W'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef BITCNT_MEM_READER_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= csr_writedata[CTRL_IRQEN_BIT];
            end
            r_irq <= r_done & r_irq_en;
        end
    end

    assign irq       = r_irq;
    assign w_ctrl_rd = {29'b0, r_irq_en, r_done, w_busy};
`else
    assign w_ctrl_rd = {30'b0, r_done, w_busy};
`endif

    always_comb begin
        w_rd_mux = '0;
        case (csr_address)
            CSR_CTRL:   w_rd_mux = w_ctrl_rd;
            CSR_BASE:   w_rd_mux = {{(32-ADDR_W){1'b0}}, r_base};
            CSR_LEN:    w_rd_mux = {{(32-LEN_W){1'b0}}, r_len};
            CSR_RESULT: w_rd_mux = {{(32-CNT_W){1'b0}}, r_result};
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_rd_valid <= w_issue;

            if (w_start) begin
                r_result   <= '0;
                r_idx      <= '0;
                r_mem_addr <= r_base;
            end else begin
                if (w_issue) begin
                    r_idx      <= r_idx + LEN_W'(1);
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                end
                if (r_rd_valid) begin
                    r_result <= r_result + CNT_W'(w_pop);
                end
            end

            // Start clears done even when the same write also requests a clear.
            if (w_start) begin
                r_done <= 1'b0;
            end else if (r_state == FIN) begin
                r_done <= 1'b1;
            end else if (w_ctrl_wr && csr_writedata[CTRL_CLEAR_BIT]) begin
                r_done <= 1'b0;
            end

            if (w_wr && !w_busy) begin
                if (csr_address == CSR_BASE) begin
                    r_base <= csr_writedata[ADDR_W-1:0];
                end
                if (csr_address == CSR_LEN) begin
                    r_len <= w_len_in;
                end
            end

            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign csr_readdata   = r_readdata;
    assign mem_address    = r_mem_addr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_bitcnt_mem_reader.sv
// tb/tb_bitcnt_mem_reader.sv - scoreboard bench for bitcnt_mem_reader
module tb_bitcnt_mem_reader;
    import bitcnt_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        csr_address;
    logic              csr_chipselect;
    logic              csr_write;
    logic              csr_read;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
`ifdef BITCNT_MEM_READER_IRQ_EN
    logic              irq;
`endif

    bitcnt_mem_reader dut (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_read       (csr_read),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
`ifdef BITCNT_MEM_READER_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: 1-cycle read latency
    logic [63:0] mem [1024];
    logic [63:0] mem_q;
    always @(posedge clk) if (mem_chipselect) mem_q <= mem[mem_address];
    assign mem_readdata = mem_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int at; } iss_t;
    typedef struct { logic [31:0] v; string name; } rd_t;
    iss_t q_iss[$];
    rd_t  q_rd[$];

    int n_checks = 0;
    int n_err    = 0;
    int t0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares read data and memory issues against the queues
    initial begin
        logic rd_flag;
        iss_t e;
        rd_t  r;
        forever begin
            @(posedge clk);
            rd_flag = csr_chipselect && csr_read && !reset;
            @(negedge clk);
            if (rd_flag) begin
                if (q_rd.size() == 0) begin
                    chk("unexpected_read", csr_readdata, 32'hx);
                end else begin
                    r = q_rd.pop_front();
                    chk(r.name, csr_readdata, r.v);
                end
            end
            if (mem_chipselect) begin
                if (q_iss.size() == 0) begin
                    chk("unexpected_issue", 32'(mem_address), 32'hx);
                end else begin
                    e = q_iss.pop_front();
                    chk("issue_addr", 32'(mem_address), 32'(e.addr));
                    chk("issue_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        csr_chipselect = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_t r;
        r.v = exp; r.name = name;
        q_rd.push_back(r);
        csr_chipselect = 1'b1; csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_issues(input int base, input int n, input int start_cyc);
        iss_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = (base + i) % 1024;
            e.at   = start_cyc + 1 + i;
            q_iss.push_back(e);
        end
    endtask

    // Full run with cycle-exact busy/done checks
    task automatic run(input int base, input int len, input int exp_res, input string tag);
        int k;
        wr(CSR_BASE, 32'(base));
        wr(CSR_LEN, 32'(len));
        t0 = cyc;
        push_issues(base, len, t0);
        wr(CSR_CTRL, 32'h1);
        k = (len == 0) ? 1 : len + 2;
        idle(k - 1);
        rd(CSR_CTRL, 32'h1, {tag, "_busy_last"});
        rd(CSR_CTRL, 32'h2, {tag, "_done"});
        rd(CSR_RESULT, 32'(exp_res), {tag, "_result"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
        reset = 1'b1; csr_chipselect = 1'b0; csr_write = 1'b0; csr_read = 1'b0;
        csr_address = 2'd0; csr_writedata = 32'h0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        rd(CSR_CTRL,   32'h0, "rst_ctrl");
        rd(CSR_BASE,   32'h0, "rst_base");
        rd(CSR_LEN,    32'h0, "rst_len");
        rd(CSR_RESULT, 32'h0, "rst_result");

        // Single all-ones word at address 0
        mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run(0, 1, 64, "one_word");

        // Wrap past the top of memory
        for (int i = 0; i < 4; i++) begin
            mem[1020 + i] = 64'h1;
            mem[i]        = 64'h1;
        end
        run(1020, 8, 8, "wrap");

        // Zero length and LEN clamp
        run(0, 0, 0, "len0");
        wr(CSR_LEN, 32'd2000);
        rd(CSR_LEN, 32'd1024, "len_clamp");

        // Mixed words; start and BASE write while busy are ignored
        mem[100] = 64'h0F; mem[101] = 64'hF0; mem[102] = 64'h0;
        mem[103] = 64'h8000_0000_0000_0001;
        wr(CSR_BASE, 32'd100);
        wr(CSR_LEN, 32'd4);
        t0 = cyc;
        push_issues(100, 4, t0);
        wr(CSR_CTRL, 32'h1);
        wr(CSR_CTRL, 32'h1);
        wr(CSR_BASE, 32'd500);
        idle(3);
        rd(CSR_CTRL, 32'h1, "mid_busy_last");
        rd(CSR_CTRL, 32'h2, "mid_done");
        rd(CSR_RESULT, 32'd10, "mid_result");
        rd(CSR_BASE, 32'd100, "mid_base_kept");
        idle(4);
        rd(CSR_CTRL, 32'h2, "mid_single_done");

        // Start together with done-clear: start wins, done cleared
        mem[200] = 64'h3;
        wr(CSR_BASE, 32'd200);
        wr(CSR_LEN, 32'd1);
        t0 = cyc;
        push_issues(200, 1, t0);
        wr(CSR_CTRL, 32'h3);
        rd(CSR_CTRL, 32'h1, "sc_started");
        idle(1);
        rd(CSR_CTRL, 32'h1, "sc_busy_last");
        rd(CSR_CTRL, 32'h2, "sc_done");
        rd(CSR_RESULT, 32'd2, "sc_result");
        wr(CSR_CTRL, 32'h2);
        rd(CSR_CTRL, 32'h0, "done_cleared");

        // Reset during RUN aborts
        wr(CSR_BASE, 32'd0);
        wr(CSR_LEN, 32'd8);
        t0 = cyc;
        push_issues(0, 4, t0);
        wr(CSR_CTRL, 32'h1);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(CSR_CTRL, 32'h0, "abort_ctrl");
        rd(CSR_RESULT, 32'h0, "abort_result");
        rd(CSR_LEN, 32'h0, "abort_len");
        mem[5] = 64'hFF; mem[6] = 64'hAAAA_AAAA_AAAA_AAAA; mem[7] = 64'h1;
        run(5, 3, 41, "after_abort");

`ifdef BITCNT_MEM_READER_IRQ_EN
        wr(CSR_BASE, 32'd0);
        wr(CSR_LEN, 32'd1);
        t0 = cyc;
        push_issues(0, 1, t0);
        wr(CSR_CTRL, 32'h5);
        idle(3);
        chk("irq_before", 32'(irq), 32'h0);
        idle(1);
        chk("irq_set", 32'(irq), 32'h1);
        wr(CSR_CTRL, 32'h6);
        chk("irq_hold", 32'(irq), 32'h1);
        idle(1);
        chk("irq_clear", 32'(irq), 32'h0);
        rd(CSR_CTRL, 32'h4, "irq_ctrl");
`endif

        idle(3);
        chk("rd_queue_empty", 32'(q_rd.size()), 32'h0);
        chk("issue_queue_empty", 32'(q_iss.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bitcnt_mem_reader.md
Name: bitcnt_mem_reader

Overview:
- Downstream consumer of the 1024 x 64-bit on-chip memory (word address, single-port, 1-cycle read latency, unregistered q).
- Nios II programs base/length over a CSR slave and pulses start.
- Block streams words out of memory through its master-side read port, popcounts each 64-bit word and accumulates the total ones count.
- Software reads the result once done is set.

Parameters:
- ADDR_W, 10, memory word-address width (depth 2^ADDR_W = 1024).
- DATA_W, 64, memory data width; fixed 64 for the popcount tree.
- CNT_W, 17, result width (1024*64 = 65536 needs 17 bits).

Ports:
- clk  in  1  system clock (only clock).
- reset  in  1  synchronous, active-high reset.
- csr_address  in  2  CSR word select: 0 CTRL, 1 BASE, 2 LEN, 3 RESULT.
- csr_chipselect  in  1  CSR access qualifier.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, registered, 1-cycle latency.
- mem_address  out  ADDR_W  memory word address.
- mem_chipselect  out  1  memory access enable; high only on issue cycles.
- mem_write  out  1  tied 0.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  memory q, valid the cycle after the address is issued.

Behaviour:
- Reset (synchronous) clears: state=IDLE, BASE=0, LEN=0, RESULT=0, done=0, csr_readdata=0, mem_address=0, mem_chipselect=0, internal rd_valid=0. Reset mid-run aborts immediately; no partial result is kept.
- CSR writes (csr_chipselect & csr_write):
  - CTRL bit0=1 starts a run (only when IDLE).
  - CTRL bit1=1 clears done (write-1-to-clear).
  - BASE takes bits[ADDR_W-1:0]; LEN takes bits[10:0], clamped to 1024 if greater.
  - BASE/LEN writes are ignored while busy; start while busy is ignored.
- CSR reads:
  - CTRL returns {30'b0, done, busy}.
  - BASE and LEN return their zero-extended values.
  - RESULT returns the zero-extended count.
  - csr_readdata updates on the cycle after csr_read; it holds its value otherwise.
- FSM:
  - IDLE: on start, RESULT←0, done←0, idx←0. Go to RUN if LEN>0; else go to FIN.
  - RUN: each cycle mem_chipselect=1, mem_address=(BASE+idx) mod 1024 (wraps past 1023 to 0), idx++. After issuing word LEN-1, go to DRAIN.
  - DRAIN: one cycle with no issue, waits for the last read data. Then go to FIN.
  - FIN: done←1, busy←0, go to IDLE.
- Datapath:
  - rd_valid = mem_chipselect delayed by 1 cycle.
  - When rd_valid, RESULT += popcount(mem_readdata). Width-extend to CNT_W; the sum cannot overflow.
- Latency (start written at cycle 0, LEN=N>0):
  - Issues in cycles 1..N.
  - Data accumulated at the ends of cycles 2..N+1.
  - done and final RESULT visible at cycle N+3.
  - LEN=0: done visible at cycle 2, RESULT=0.
- busy = (state != IDLE && state != FIN) or a pending FIN.
- Start concurrent with a done-clear in the same CTRL write: start wins, and done is cleared by the start.

Optional Feature:
- Macro BITCNT_MEM_READER_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and CTRL bit2 = irq_enable (read/write, reset 0).
  - irq = done & irq_enable, registered; it drops the cycle after done is cleared.
  - CTRL readback becomes {29'b0, irq_enable, done, busy}.
- When undefined: no irq port; CTRL bit2 is ignored on write and reads 0.

Decomposition:
- Package bitcnt_pkg holds:
  - CSR offset constants (CSR_CTRL=0, CSR_BASE=1, CSR_LEN=2, CSR_RESULT=3).
  - CTRL bit positions.
  - FSM state enum {IDLE, RUN, DRAIN, FIN}.
  - Width constants ADDR_W/DATA_W/CNT_W and LEN_MAX=1024.
- One sub-module, bitcnt_popcount64: purely combinational 64-bit-in, 7-bit-out adder tree, instantiated once on mem_readdata.

Test Plan:
- BASE=0, LEN=1, mem[0]=64'hFFFF_FFFF_FFFF_FFFF, start → one issue at address 0; RESULT=64, done=1 at cycle 4; CTRL reads 32'h2.
- BASE=1020, LEN=8, every word 64'h1 → addresses 1020,1021,1022,1023,0,1,2,3 in consecutive cycles; RESULT=8.
- LEN=0, start → no mem_chipselect pulse; done=1 at cycle 2; RESULT=0. LEN written as 2000 reads back 1024.
- LEN=4 run with words 64'h0F, 64'hF0, 0, 64'h8000_0000_0000_0001 → RESULT=10. A second start and a BASE write issued mid-run are ignored: BASE unchanged, single done.
- Reset asserted during RUN → next cycle mem_chipselect=0, CTRL=0, RESULT=0. A new run afterwards completes correctly.
- With BITCNT_MEM_READER_IRQ_EN, CTRL write 32'h5 (start plus irq_enable) → irq=1 one cycle after done. CTRL write 32'h6 → irq=0 the following cycle.
